jh_step_ctrl: RTL and testbench

Command-driven sequencer for a Johnson-counter phase register, such as a stepper or phase-select generator. It accepts a move command (step count, direction, step-rate divider) over a valid/ready handshake. It then steps an internal WIDTH-bit Johnson register at the programmed rate, with pause and abort support, and detects and recovers from illegal Johnson states. It sits between a command master and the phase-driven datapath that consumes q.

---
 rtl/jh_step_ctrl.sv | 117 +++++++++++
 tb/tb_jh_step_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/jh_step_ctrl.sv
// Command-driven Johnson phase sequencer: accepts a move (steps, direction, rate),
// steps q at the programmed rate with pause/abort, and self-heals from illegal q values.
module jh_step_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             step_pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output logic             err_illegal
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] q_reg;
  logic [DIV_W-1:0] presc_reg;
  logic [DIV_W-1:0] div_reg;
  logic             dir_reg;
  logic [CNT_W-1:0] steps_left_reg;
  logic             step_pulse_reg;
  logic             err_reg;

  logic [WIDTH-1:0] q_fwd;
  logic [WIDTH-1:0] q_rev;
  logic [WIDTH-1:0] q_inv;
  logic             q_legal;

  assign q_fwd = {q_reg[WIDTH-2:0], ~q_reg[WIDTH-1]};
  assign q_rev = {~q_reg[0], q_reg[WIDTH-1:1]};
  assign q_inv = ~q_reg;

  // Legal Johnson values are a run of 1s or a run of 0s anchored at the LSB,
  // i.e. q or ~q has the form 2^k-1.
  assign q_legal = ((q_reg & (q_reg + Q_ONE)) == '0) ||
                   ((q_inv & (q_inv + Q_ONE)) == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      q_reg          <= '0;
      presc_reg      <= '0;
      div_reg        <= '0;
      dir_reg        <= 1'b0;
      steps_left_reg <= '0;
      step_pulse_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      step_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            dir_reg        <= cmd_dir;
            div_reg        <= cmd_div;
            steps_left_reg <= cmd_steps;
            presc_reg      <= '0;
            err_reg        <= 1'b0;
            state_reg      <= (cmd_steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= DONE;
          end else if (pause) begin
            state_reg <= HOLD;
          end else if (presc_reg == div_reg) begin
            presc_reg <= '0;
            // An illegal q consumes the step slot without counting it.
            if (q_legal) begin
              q_reg          <= dir_reg ? q_rev : q_fwd;
              step_pulse_reg <= 1'b1;
              steps_left_reg <= steps_left_reg - CNT_ONE;
              if (steps_left_reg == CNT_ONE) state_reg <= DONE;
            end
          end else begin
            presc_reg <= presc_reg + DIV_ONE;
          end
        end
        HOLD: begin
          if (abort)       state_reg <= DONE;
          else if (!pause) state_reg <= RUN;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      if (!q_legal) begin
        q_reg   <= '0;
        err_reg <= 1'b1;
      end
    end
  end

  assign q           = q_reg;
  assign step_pulse  = step_pulse_reg;
  assign steps_left  = steps_left_reg;
  assign err_illegal = err_reg;
  assign cmd_ready   = (state_reg == IDLE);
  assign busy        = (state_reg == RUN) || (state_reg == HOLD);
  assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_jh_step_ctrl.sv
// Directed bench for jh_step_ctrl: inputs driven and outputs sampled 1ns after each rising edge.
module tb_jh_step_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_steps;
  logic       cmd_dir;
  logic [7:0] cmd_div;
  logic       pause;
  logic       abort;
  logic [3:0] q;
  logic       step_pulse;
  logic       busy;
  logic       done;
  logic [7:0] steps_left;
  logic       err_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jh_step_ctrl #(.WIDTH(4), .CNT_W(8), .DIV_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
    .cmd_dir(cmd_dir), .cmd_div(cmd_div), .pause(pause), .abort(abort),
    .q(q), .step_pulse(step_pulse), .busy(busy), .done(done),
    .steps_left(steps_left), .err_illegal(err_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] s, input logic d, input logic [7:0] v);
    cmd_valid = 1'b1; cmd_steps = s; cmd_dir = d; cmd_div = v;
    tick();
    cmd_valid = 1'b0;
    $display("cmd steps=%0d dir=%0d div=%0d -> q=%b steps_left=%0d", s, d, v, q, steps_left);
  endtask

  logic [3:0] fwd8 [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                           4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] seq6 [6] = '{4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; cmd_div = '0;
    pause = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err_illegal), 32'h0);
    chk("rst_steps_left", 32'(steps_left), 32'h0);
    chk("rst_pulse", 32'(step_pulse), 32'h0);
    reset = 1'b1;
    tick();

    // Forward 8 steps at full rate
    issue(8'd8, 1'b0, 8'd0);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_sl0", 32'(steps_left), 32'd8);
    for (int i = 0; i < 8; i++) begin
      tick();
      $display("t1 edge %0d q=%b pulse=%0d", i + 1, q, step_pulse);
      chk("t1_q", 32'(q), 32'(fwd8[i]));
      chk("t1_pulse", 32'(step_pulse), 32'h1);
      chk("t1_sl", 32'(steps_left), 32'(7 - i));
    end
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_ready_in_done", 32'(cmd_ready), 32'h0);
    tick();
    chk("t1_ready", 32'(cmd_ready), 32'h1);
    chk("t1_done_clr", 32'(done), 32'h0);
    chk("t1_pulse_clr", 32'(step_pulse), 32'h0);

    // Reverse 2 steps, div=3
    issue(8'd2, 1'b1, 8'd3);
    tick(); tick(); tick();
    chk("t2_q_wait", 32'(q), 32'h0);
    chk("t2_pulse_wait", 32'(step_pulse), 32'h0);
    tick();
    $display("t2 E4 q=%b sl=%0d", q, steps_left);
    chk("t2_q1", 32'(q), 32'b1000);
    chk("t2_pulse1", 32'(step_pulse), 32'h1);
    chk("t2_sl1", 32'(steps_left), 32'd1);
    tick(); tick(); tick();
    chk("t2_q_hold", 32'(q), 32'b1000);
    tick();
    $display("t2 E8 q=%b sl=%0d done=%0d", q, steps_left, done);
    chk("t2_q2", 32'(q), 32'b1100);
    chk("t2_sl2", 32'(steps_left), 32'd0);
    chk("t2_done", 32'(done), 32'h1);
    tick();

    // Forward 6 steps, div=1, pause for 5 cycles after the 2nd step
    issue(8'd6, 1'b0, 8'd1);
    for (int k = 0; k < 2; k++) begin
      tick(); chk("t3_gap", 32'(step_pulse), 32'h0);
      tick(); chk("t3_q_pre", 32'(q), 32'(seq6[k]));
    end
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_q_paused", 32'(q), 32'(seq6[1]));
      chk("t3_pulse_paused", 32'(step_pulse), 32'h0);
    end
    chk("t3_busy_hold", 32'(busy), 32'h1);
    pause = 1'b0;
    tick();
    chk("t3_resume_q", 32'(q), 32'(seq6[1]));
    chk("t3_resume_pulse", 32'(step_pulse), 32'h0);
    for (int k = 2; k < 6; k++) begin
      tick(); chk("t3_gap2", 32'(step_pulse), 32'h0);
      tick();
      $display("t3 step %0d q=%b sl=%0d", k + 1, q, steps_left);
      chk("t3_q_post", 32'(q), 32'(seq6[k]));
      chk("t3_pulse_post", 32'(step_pulse), 32'h1);
    end
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_sl", 32'(steps_left), 32'd0);
    tick();

    // Abort after 3rd step of 10
    issue(8'd10, 1'b0, 8'd0);
    tick(); tick(); tick();
    chk("t4_q3", 32'(q), 32'b1000);
    abort = 1'b1;
    tick();
    $display("t4 abort q=%b sl=%0d done=%0d", q, steps_left, done);
    chk("t4_q", 32'(q), 32'b1000);
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_sl", 32'(steps_left), 32'd7);
    chk("t4_pulse", 32'(step_pulse), 32'h0);
    abort = 1'b0;
    tick();
    chk("t4_pulse_after", 32'(step_pulse), 32'h0);
    chk("t4_ready", 32'(cmd_ready), 32'h1);
    chk("t4_q_after", 32'(q), 32'b1000);

    // Zero-step command
    issue(8'd0, 1'b0, 8'd0);
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_q", 32'(q), 32'b1000);
    chk("t5_pulse", 32'(step_pulse), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    tick();
    chk("t5_ready", 32'(cmd_ready), 32'h1);

    // Illegal state injected mid-run
    issue(8'd4, 1'b0, 8'd0);
    tick();
    chk("t6_q1", 32'(q), 32'b0000);
    chk("t6_sl1", 32'(steps_left), 32'd3);
    force dut.q_reg = 4'b0101;
    #1;
    release dut.q_reg;
    chk("t6_forced", 32'(q), 32'b0101);
    tick();
    $display("t6 recover q=%b err=%0d sl=%0d", q, err_illegal, steps_left);
    chk("t6_q_rec", 32'(q), 32'b0000);
    chk("t6_err", 32'(err_illegal), 32'h1);
    chk("t6_sl_keep", 32'(steps_left), 32'd3);
    chk("t6_pulse", 32'(step_pulse), 32'h0);
    chk("t6_busy", 32'(busy), 32'h1);
    tick(); tick(); tick();
    chk("t6_q_end", 32'(q), 32'b0111);
    chk("t6_done", 32'(done), 32'h1);
    tick();
    chk("t6_err_sticky", 32'(err_illegal), 32'h1);
    issue(8'd0, 1'b0, 8'd0);
    chk("t6_err_clr", 32'(err_illegal), 32'h0);
    tick();

    // Asynchronous reset mid-run
    issue(8'd5, 1'b0, 8'd2);
    tick();
    #2 reset = 1'b0;
    #1;
    $display("t7 async reset q=%b busy=%0d ready=%0d", q, busy, cmd_ready);
    chk("t7_q", 32'(q), 32'h0);
    chk("t7_busy", 32'(busy), 32'h0);
    chk("t7_ready", 32'(cmd_ready), 32'h1);
    chk("t7_sl", 32'(steps_left), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
